// File: rtl/imm_arbiter.sv
// -----------------------------------------------------------------------------
// imm_arbiter
//
// Purpose:
//   Two-port round-robin arbiter that lets decode (port 0) and the early
//   branch-target unit (port 1) share one immediate generator. The winning
//   request's immediate is registered into a single-entry response buffer
//   with valid/ready flow control. No combinational path runs from either
//   instruction input to any output.
//
// Parameters:
//   XLEN            datapath width of the generated immediate (>= 32 typical)
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_req0_valid    port 0 request valid
//   o_req0_ready    port 0 granted this cycle (combinational)
//   i_req0_instr    port 0 instruction word
//   i_req1_valid    port 1 request valid
//   o_req1_ready    port 1 granted this cycle (combinational)
//   i_req1_instr    port 1 instruction word
//   o_rsp_valid     response buffer holds a result
//   i_rsp_ready     consumer takes the buffered result
//   o_rsp_id        port that issued the buffered result
//   o_rsp_imm       sign-extended immediate
//
// Optional feature (macro IMM_ARB_PC_ADD_EN):
//   i_req0_pc       port 0 PC (XLEN)
//   i_req1_pc       port 1 PC (XLEN)
//   o_rsp_target    registered pc + imm, modulo 2^XLEN
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// imm_gen
//
// Purpose:
//   Purely combinational RISC-V immediate decoder. Selects the format from
//   the opcode field and sign-extends from instr[31] to XLEN.
//
// Ports:
//   instr   32-bit instruction word
//   imm     sign-extended immediate (XLEN)
// -----------------------------------------------------------------------------
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // 32-bit sign-extended form; widened or narrowed to XLEN below.
  logic [31:0] imm32;
  logic        sign;

  assign sign = instr[31];

  always_comb begin
    imm32 = {{20{sign}}, instr[31:20]};
    case (instr[6:0])
      OP_LUI,
      OP_AUIPC:  imm32 = {instr[31:12], 12'b0};
      OP_STORE:  imm32 = {{20{sign}}, instr[31:25], instr[11:7]};
      OP_BRANCH: imm32 = {{19{sign}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      OP_JAL:    imm32 = {{11{sign}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default:   imm32 = {{20{sign}}, instr[31:20]};
    endcase
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_trunc
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

endmodule

module imm_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [31:0]     i_req0_instr,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [31:0]     i_req1_instr,

`ifdef IMM_ARB_PC_ADD_EN
  input  logic [XLEN-1:0] i_req0_pc,
  input  logic [XLEN-1:0] i_req1_pc,
  output logic [XLEN-1:0] o_rsp_target,
`endif

  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_imm
);

  // ---------------------------------------------------------------------------
  // Response buffer state
  // ---------------------------------------------------------------------------
  logic            rsp_valid_reg;
  logic            rsp_id_reg;
  logic [XLEN-1:0] rsp_imm_reg;
  logic            rr_last_reg;   // port granted most recently

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       free;
  logic       accept;
  logic       sel;

  assign req_valid = {i_req1_valid, i_req0_valid};

  // Buffer can take a new result if empty or being drained this cycle.
  assign free = !rsp_valid_reg || i_rsp_ready;

  // Each port wins when it requests alone, or on a tie when it was not the
  // last winner. Grants depend only on valids and state, never on the other
  // port's grant, so there is no ready-to-ready loop. Reset forces both low.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      localparam logic PORT = (gi == 1);
      assign grant[gi] = !i_rst && free && req_valid[gi] &&
                         (!req_valid[1-gi] || (rr_last_reg != PORT));
    end
  endgenerate

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];

  // Grants are already qualified by valid, so any grant is an accept.
  assign accept = |grant;
  assign sel    = grant[1];

  // ---------------------------------------------------------------------------
  // Shared immediate generator, fed by the winning port
  // ---------------------------------------------------------------------------
  logic [31:0]     instr_mux;
  logic [XLEN-1:0] imm_next;

  assign instr_mux = sel ? i_req1_instr : i_req0_instr;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (instr_mux),
    .imm   (imm_next)
  );

  // ---------------------------------------------------------------------------
  // Buffer update: accept overwrites (even while draining), otherwise a
  // drain clears valid and the data fields hold their last value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_imm_reg   <= '0;
      rr_last_reg   <= 1'b1;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= sel;
      rsp_imm_reg   <= imm_next;
      rr_last_reg   <= sel;
    end else if (i_rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_id    = rsp_id_reg;
  assign o_rsp_imm   = rsp_imm_reg;

`ifdef IMM_ARB_PC_ADD_EN
  // ---------------------------------------------------------------------------
  // Branch/jump target, registered alongside the immediate
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_mux;
  logic [XLEN-1:0] target_next;
  logic [XLEN-1:0] rsp_target_reg;

  assign pc_mux      = sel ? i_req1_pc : i_req0_pc;
  assign target_next = pc_mux + imm_next;   // wraps modulo 2^XLEN

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_target_reg <= '0;
    end else if (accept) begin
      rsp_target_reg <= target_next;
    end
  end

  assign o_rsp_target = rsp_target_reg;
`endif

endmodule

// File: tb/tb_imm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imm_arbiter
//
// Purpose:
//   Directed self-checking bench for imm_arbiter: reset state, every
//   immediate format through port 0, round-robin tie alternation, response
//   backpressure, reset in the middle of a stream and, when
//   IMM_ARB_PC_ADD_EN is defined, the pc + imm target including wrap-around.
//   Inputs change 1 ns after the rising edge; outputs are sampled well
//   before the next rising edge.
// -----------------------------------------------------------------------------
module tb_imm_arbiter;

  localparam int XLEN = 32;

  logic            i_clk;
  logic            i_rst;
  logic            i_req0_valid;
  logic            o_req0_ready;
  logic [31:0]     i_req0_instr;
  logic            i_req1_valid;
  logic            o_req1_ready;
  logic [31:0]     i_req1_instr;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic            o_rsp_id;
  logic [XLEN-1:0] o_rsp_imm;
`ifdef IMM_ARB_PC_ADD_EN
  logic [XLEN-1:0] i_req0_pc;
  logic [XLEN-1:0] i_req1_pc;
  logic [XLEN-1:0] o_rsp_target;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  imm_arbiter #(
    .XLEN (XLEN)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_instr (i_req0_instr),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_instr (i_req1_instr),
`ifdef IMM_ARB_PC_ADD_EN
    .i_req0_pc    (i_req0_pc),
    .i_req1_pc    (i_req1_pc),
    .o_rsp_target (o_rsp_target),
`endif
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_imm    (o_rsp_imm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Port-0 format vectors and their hand-decoded immediates.
  logic [31:0] fmt_instr [5];
  logic [31:0] fmt_imm   [5];

  initial begin
    fmt_instr[0] = 32'hFFF00093; fmt_imm[0] = 32'hFFFFFFFF;  // I
    fmt_instr[1] = 32'h123450B7; fmt_imm[1] = 32'h12345000;  // U
    fmt_instr[2] = 32'h00112223; fmt_imm[2] = 32'h00000004;  // S
    fmt_instr[3] = 32'h00000463; fmt_imm[3] = 32'h00000008;  // B
    fmt_instr[4] = 32'hFFDFF06F; fmt_imm[4] = 32'hFFFFFFFC;  // J

    i_rst        = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_instr = 32'h0;
    i_req1_instr = 32'h0;
    i_rsp_ready  = 1'b1;
`ifdef IMM_ARB_PC_ADD_EN
    i_req0_pc    = '0;
    i_req1_pc    = '0;
`endif

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_ready0", 64'(o_req0_ready), 64'd0);
    check("rst_ready1", 64'(o_req1_ready), 64'd0);
    check("rst_valid",  64'(o_rsp_valid),  64'd0);
    check("rst_id",     64'(o_rsp_id),     64'd0);
    check("rst_imm",    64'(o_rsp_imm),    64'd0);
`ifdef IMM_ARB_PC_ADD_EN
    check("rst_target", 64'(o_rsp_target), 64'd0);
`endif

    // ---------------- single formats on port 0 ----------------
    i_rst        = 1'b0;
    i_req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_req0_instr = fmt_instr[k];
      #1;
      check($sformatf("fmt%0d_ready0", k), 64'(o_req0_ready), 64'd1);
      check($sformatf("fmt%0d_ready1", k), 64'(o_req1_ready), 64'd0);
      tick();
      check($sformatf("fmt%0d_valid", k), 64'(o_rsp_valid), 64'd1);
      check($sformatf("fmt%0d_id", k),    64'(o_rsp_id),    64'd0);
      check($sformatf("fmt%0d_imm", k),   64'(o_rsp_imm),   64'(fmt_imm[k]));
      $display("fmt %0d: instr=0x%08h imm=0x%08h id=%0d", k, fmt_instr[k], o_rsp_imm, o_rsp_id);
    end

    // Drain with nothing requesting: valid drops, data holds.
    i_req0_valid = 1'b0;
    tick();
    check("drain_valid", 64'(o_rsp_valid), 64'd0);
    check("drain_imm",   64'(o_rsp_imm),   64'hFFFFFFFC);

    // ---------------- tie after reset alternates 0,1,0,1 ----------------
    i_rst = 1'b1;
    tick();
    i_rst        = 1'b0;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_instr = 32'hFFF00093;   // imm 0xFFFFFFFF
    i_req1_instr = 32'h123450B7;   // imm 0x12345000
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("tie%0d_ready0", k), 64'(o_req0_ready), 64'((k % 2) == 0));
      check($sformatf("tie%0d_ready1", k), 64'(o_req1_ready), 64'((k % 2) == 1));
      tick();
      check($sformatf("tie%0d_valid", k), 64'(o_rsp_valid), 64'd1);
      check($sformatf("tie%0d_id", k),    64'(o_rsp_id),    64'(k % 2));
      check($sformatf("tie%0d_imm", k),   64'(o_rsp_imm),
            ((k % 2) == 0) ? 64'hFFFFFFFF : 64'h12345000);
      $display("tie %0d: id=%0d imm=0x%08h", k, o_rsp_id, o_rsp_imm);
    end

    // ---------------- backpressure ----------------
    // Buffer holds id 1 / 0x12345000; port 1 now waits with a store.
    i_req0_valid = 1'b0;
    i_req1_instr = 32'h00112223;   // imm 0x4
    i_rsp_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready0", k), 64'(o_req0_ready), 64'd0);
      check($sformatf("bp%0d_ready1", k), 64'(o_req1_ready), 64'd0);
      tick();
      check($sformatf("bp%0d_valid", k), 64'(o_rsp_valid), 64'd1);
      check($sformatf("bp%0d_id", k),    64'(o_rsp_id),    64'd1);
      check($sformatf("bp%0d_imm", k),   64'(o_rsp_imm),   64'h12345000);
      $display("stall %0d: id=%0d imm=0x%08h", k, o_rsp_id, o_rsp_imm);
    end
    i_rsp_ready = 1'b1;
    #1;
    check("bp_release_ready1", 64'(o_req1_ready), 64'd1);
    tick();
    check("bp_release_valid", 64'(o_rsp_valid), 64'd1);
    check("bp_release_id",    64'(o_rsp_id),    64'd1);
    check("bp_release_imm",   64'(o_rsp_imm),   64'h00000004);

    // ---------------- reset mid-stream ----------------
    // Make port 0 the last winner so an un-reset tie would go to port 1.
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b0;
    i_req0_instr = 32'hFFF00093;
    tick();
    check("pre_rst_id", 64'(o_rsp_id), 64'd0);
    i_req1_valid = 1'b1;
    i_rst        = 1'b1;
    #1;
    check("mid_rst_ready0", 64'(o_req0_ready), 64'd0);
    check("mid_rst_ready1", 64'(o_req1_ready), 64'd0);
    tick();
    check("mid_rst_valid", 64'(o_rsp_valid), 64'd0);
    check("mid_rst_imm",   64'(o_rsp_imm),   64'd0);
    i_rst        = 1'b0;
    i_req0_instr = 32'h00000463;   // imm 0x8
    i_req1_instr = 32'hFFDFF06F;   // imm 0xFFFFFFFC
    #1;
    check("post_rst_ready0", 64'(o_req0_ready), 64'd1);
    check("post_rst_ready1", 64'(o_req1_ready), 64'd0);
    tick();
    check("post_rst_id",  64'(o_rsp_id),  64'd0);
    check("post_rst_imm", 64'(o_rsp_imm), 64'h00000008);
    $display("post-reset grant: id=%0d imm=0x%08h", o_rsp_id, o_rsp_imm);

`ifdef IMM_ARB_PC_ADD_EN
    // ---------------- pc + imm target ----------------
    i_req1_valid = 1'b0;
    i_req0_pc    = 32'h00001000;
    i_req0_instr = 32'hFFDFF06F;
    tick();
    check("pc_target_jal", 64'(o_rsp_target), 64'h00000FFC);
    $display("pc add: pc=0x00001000 target=0x%08h", o_rsp_target);
    i_req0_pc    = 32'hFFFFFFFC;
    i_req0_instr = 32'h00000463;
    tick();
    check("pc_target_wrap", 64'(o_rsp_target), 64'h00000004);
    $display("pc add: pc=0xFFFFFFFC target=0x%08h", o_rsp_target);
`endif

    // ---------------- idle drain ----------------
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick();
    check("final_valid", 64'(o_rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
